param_mem: RTL and testbench

Parametrised successor to the single-port test memory. Generalised in data width, depth and read latency, with byte-enable writes, valid/ready request handshake, a pipelined response channel, out-of-range error reporting and hardware clear-on-reset. Sits behind the memory interface as the DUT for the next-generation verification environment.

---
 rtl/param_mem_pkg.sv | 13 +
 rtl/param_mem_pipe.sv | 37 +++
 rtl/param_mem.sv | 155 +++++++++++++++
 tb/tb_param_mem.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_mem_pkg.sv
// Shared types and limits for the parametrised test memory.
package param_mem_pkg;

    // Controller states: CLEAR zero-fills the array, RUN serves requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Deepest response pipeline the block supports.
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/param_mem_pipe.sv
// Fixed-latency valid+payload delay line with synchronous flush.
module param_mem_pipe #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_r [LAT];
    logic [W-1:0] data_r  [LAT];

    // Shift valid and payload one stage per cycle; rst drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                valid_r[i] <= 1'b0;
                data_r[i]  <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in_data;
            for (int i = 1; i < LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LAT-1];
    assign out_data  = data_r[LAT-1];

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port memory: byte-enable writes, valid/ready requests,
// fixed-latency in-order responses, range errors and zero-fill after reset.
module param_mem
    import param_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic                  rsp_we,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Out-of-range latency parameters are pinned to the nearest legal value.
    localparam int LAT   = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam logic [ADDR_W:0]  DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef struct packed {
        logic              we;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    // Overlay the enabled bytes of new_word onto old_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    state_t            state_r;
    logic [IDX_W-1:0]  clr_addr_r;
    logic              accept_s;
    logic              in_range_s;
    logic [IDX_W-1:0]  idx_s;
    rsp_t              rsp_in_s;
    rsp_t              rsp_out_s;
    logic              rsp_valid_s;

    assign accept_s   = req_valid & req_ready;
    assign in_range_s = ({1'b0, req_addr} < DEPTH_L);
    assign idx_s      = req_addr[IDX_W-1:0];

    // Storage: zero-fill during CLEAR, byte-merged writes in RUN; rst writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
        end else if (state_r == CLEAR) begin
            mem_r[clr_addr_r] <= '0;
        end else if (accept_s && req_we && in_range_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], req_wdata, req_be);
        end
    end

    // Controller: clear sequencing, ready/busy flags and the saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CLEAR;
            clr_addr_r <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            err_cnt    <= '0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clr_addr_r == LAST_IDX) begin
                        state_r    <= RUN;
                        clr_addr_r <= '0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        clr_addr_r <= clr_addr_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept_s && !in_range_s && (err_cnt != {ERR_W{1'b1}})) begin
                        err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r    <= CLEAR;
                    clr_addr_r <= '0;
                    req_ready  <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

    // Response payload captured at accept time; reads see the array before this edge's write.
    always_comb begin
        rsp_in_s = '0;
        if (accept_s) begin
            rsp_in_s.we  = req_we;
            rsp_in_s.err = ~in_range_s;
            if (in_range_s && !req_we) begin
                rsp_in_s.rdata = mem_r[idx_s];
            end else begin
                rsp_in_s.rdata = '0;
            end
        end else begin
            rsp_in_s = '0;
        end
    end

    param_mem_pipe #(
        .LAT (LAT),
        .W   (RSP_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept_s),
        .in_data   (rsp_in_s),
        .out_valid (rsp_valid_s),
        .out_data  (rsp_out_s)
    );

    assign rsp_valid = rsp_valid_s;
    assign rsp_we    = rsp_out_s.we;
    assign rsp_err   = rsp_out_s.err;
    assign rsp_rdata = rsp_out_s.rdata;

endmodule

// File: tb/tb_param_mem.sv
// Self-checking bench for param_mem with a word-array reference model.
module tb_param_mem;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 200;
    localparam int RD_LAT  = 3;
    localparam int ERR_W   = 2;
    localparam int BE_W    = DATA_W / 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ERR_W-1:0]  err_cnt;

    param_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .ERR_W  (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen so far; read at falling edges only.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rec_t;

    rec_t        obs_q[$];
    rec_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          err_m    = 0;
    int          errors   = 0;
    int          checks   = 0;
    int          idle_bad = 0;
    logic        mon_en   = 1'b0;

    // Record every response; count idle cycles with non-zero payload.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                obs_q.push_back('{cyc, rsp_we, rsp_err, rsp_rdata});
            end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_we !== 1'b0) begin
                idle_bad++;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        err_m = 0;
        exp_q.delete();
    endtask

    // Present one request for one cycle (called just after a falling edge) and
    // predict its response: due when sampled RD_LAT edges after the accept edge.
    task automatic send(input logic we, input int addr, input logic [31:0] wdata, input logic [3:0] be);
        rec_t r;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr[7:0];
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        r.cyc = cyc + RD_LAT - 1;
        r.we  = we;
        if (addr >= DEPTH) begin
            r.err   = 1'b1;
            r.rdata = 32'h0;
            if (err_m < ERR_MAX) err_m++;
        end else begin
            r.err = 1'b0;
            if (we) begin
                r.rdata = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[addr][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                r.rdata = mem_m[addr];
            end
        end
        exp_q.push_back(r);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reset pulse, reset-state checks and the timed clear sequence.
    task automatic do_reset(input logic poke);
        int n;
        int ready_bad;
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || err_cnt !== 2'd0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b busy=%b ready=%b err_cnt=%0d rdata=%h, expected 0 1 0 0 0",
                     rsp_valid, busy, req_ready, err_cnt, rsp_rdata);
        end
        rst = 1'b0;
        if (poke) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 8'd5;
        end
        n = 0;
        ready_bad = 0;
        while (busy === 1'b1 && n < DEPTH + 8) begin
            if (req_ready !== 1'b0) ready_bad++;
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL busy_len: got %0d busy cycles, expected %0d", n, DEPTH);
        end
        checks++;
        if (ready_bad != 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_clear: got %0d ready cycles while busy, ready=%b busy=%b after, expected 0 1 0",
                     ready_bad, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        mon_en = 1'b1;
    endtask

    task automatic test_clear();
        obs_q.delete();
        send(1'b1, 5, 32'hDEADBEEF, 4'hF);
        idle(RD_LAT + 2);
        obs_q.delete();
        do_reset(1'b1);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL clear_ignored: got %0d responses during clear, expected 0", obs_q.size());
        end
        send(1'b0, 5, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL clear_count: got %0d responses, expected 1", obs_q.size());
        end else if (obs_q[0].cyc != exp_q[0].cyc || obs_q[0].rdata !== 32'h0 || obs_q[0].err !== 1'b0) begin
            errors++;
            $display("FAIL clear_read: got cyc=%0d rdata=%h err=%b, expected cyc=%0d rdata=00000000 err=0",
                     obs_q[0].cyc, obs_q[0].rdata, obs_q[0].err, exp_q[0].cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_byte_en();
        logic [31:0] last;
        send(1'b1, 3, 32'h11223344, 4'hF);
        send(1'b1, 3, 32'hAABBCCDD, 4'h5);
        send(1'b0, 3, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].rdata : 32'hX;
        checks++;
        if (last !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_en_merge: got %h, expected 11bb33dd", last);
        end
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL byte_en_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].we !== exp_q[i].we ||
                obs_q[i].err !== exp_q[i].err || obs_q[i].rdata !== exp_q[i].rdata) begin
                errors++;
                $display("FAIL byte_en_rsp[%0d]: got cyc=%0d we=%b err=%b rdata=%h, expected cyc=%0d we=%b err=%b rdata=%h",
                         i, obs_q[i].cyc, obs_q[i].we, obs_q[i].err, obs_q[i].rdata,
                         exp_q[i].cyc, exp_q[i].we, exp_q[i].err, exp_q[i].rdata);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_latency();
        int n0;
        send(1'b1, 0, 32'hA0, 4'hF);
        send(1'b1, 1, 32'hA1, 4'hF);
        send(1'b1, 2, 32'hA2, 4'hF);
        idle(RD_LAT + 2);
        obs_q.delete();
        exp_q.delete();
        n0 = cyc + 1;
        send(1'b0, 0, 32'h0, 4'h0);
        send(1'b0, 1, 32'h0, 4'h0);
        send(1'b0, 2, 32'h0, 4'h0);
        idle(RD_LAT + 3);
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL latency_count: got %0d responses, expected 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            checks++;
            if (obs_q[i].cyc + 1 != n0 + RD_LAT + i || obs_q[i].rdata !== 32'hA0 + 32'(i) || obs_q[i].err !== 1'b0) begin
                errors++;
                $display("FAIL latency_rsp[%0d]: got edge N+%0d rdata=%h err=%b, expected edge N+%0d rdata=%h err=0",
                         i, obs_q[i].cyc + 1 - n0, obs_q[i].rdata, obs_q[i].err, RD_LAT + i, 32'hA0 + 32'(i));
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_out_of_range();
        send(1'b0, 250, 32'h0, 4'h0);
        send(1'b1, 201, 32'h12345678, 4'hF);
        send(1'b0, 201 % DEPTH, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        checks++;
        if (err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL oor_err_cnt: got %0d, expected 2", err_cnt);
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL oor_count: got %0d responses, expected 3", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_q[i].err !== 1'b1 || obs_q[i].rdata !== 32'h0 || obs_q[i].cyc != exp_q[i].cyc) begin
                    errors++;
                    $display("FAIL oor_rsp[%0d]: got err=%b rdata=%h cyc=%0d, expected err=1 rdata=00000000 cyc=%0d",
                             i, obs_q[i].err, obs_q[i].rdata, obs_q[i].cyc, exp_q[i].cyc);
                end
            end
            checks++;
            if (obs_q[2].rdata !== 32'hA1 || obs_q[2].err !== 1'b0) begin
                errors++;
                $display("FAIL oor_unchanged: got rdata=%h err=%b at addr 1, expected 000000a1 0", obs_q[2].rdata, obs_q[2].err);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        obs_q.delete();
        for (int k = 0; k < 5; k++) begin
            send(1'(k % 2), DEPTH + 10 * k, $urandom, 4'hF);
            idle(RD_LAT + 1);
            checks++;
            if (err_cnt !== ERR_W'((k + 1 > ERR_MAX) ? ERR_MAX : k + 1)) begin
                errors++;
                $display("FAIL sat_err_cnt[%0d]: got %0d, expected %0d", k, err_cnt, (k + 1 > ERR_MAX) ? ERR_MAX : k + 1);
            end
        end
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL sat_count: got %0d responses, expected 5", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        send(1'b0, 7, 32'h0, 4'h0);
        send(1'b0, 8, 32'h0, 4'h0);
        do_reset(1'b0);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_rsp: got %0d responses before clear done, expected 0", obs_q.size());
        end
        checks++;
        if (err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_err_cnt: got %0d, expected 0", err_cnt);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 300; k++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        idle(RD_LAT + 2);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].we !== exp_q[i].we ||
                obs_q[i].err !== exp_q[i].err || obs_q[i].rdata !== exp_q[i].rdata) begin
                errors++;
                $display("FAIL random_rsp[%0d]: got cyc=%0d we=%b err=%b rdata=%h, expected cyc=%0d we=%b err=%b rdata=%h",
                         i, obs_q[i].cyc, obs_q[i].we, obs_q[i].err, obs_q[i].rdata,
                         exp_q[i].cyc, exp_q[i].we, exp_q[i].err, exp_q[i].rdata);
            end
        end
        checks++;
        if (err_cnt !== ERR_W'(err_m)) begin
            errors++;
            $display("FAIL random_err_cnt: got %0d, expected %0d", err_cnt, err_m);
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_payload: got %0d idle cycles with non-zero payload, expected 0", idle_bad);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'd0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_clear();
        test_byte_en();
        test_latency();
        test_out_of_range();
        test_saturation();
        test_reset_mid();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
